// File: rtl/invert_pkg.sv
// Shared types and constants for the invert sweep controller.
package invert_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam int DEF_WIDTH = 8;

    // Wide enough for any practical WIDTH; users slice the low bits.
    localparam logic [63:0] RES_ALL_ONES = '1;

endpackage

// File: rtl/invert_lat_cnt.sv
// Latency down-counter: loadable, decrements on request, flags a count of one.
module invert_lat_cnt #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          at_one
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_one = (cnt_q == CW'(1));

endmodule

// File: rtl/invert_ctrl.sv
// Sweep controller feeding the invert stage and collecting its (y, x) results.
// Optional macro INVERT_CTRL_SKIP_ZERO_EN: y=0 is not launched; its result is reported as all-ones.
//
// state   | meaning
// IDLE    | waiting for en; y=0
// LAUNCH  | drive y=cur with a one-cycle start
// WAIT    | hold y while invert computes
// CAPTURE | sample x, register the (cur, x) result, advance or finish
// DONE    | one cycle after the last capture; done pulses the cycle after
module invert_ctrl
    import invert_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int LATENCY = 16,
    parameter int Y_START = 1,
    parameter int Y_END   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             start,
    output logic [WIDTH-1:0] res_y,
    output logic [WIDTH-1:0] res_x,
    output logic             res_valid,
    output logic             busy,
    output logic             done
);

    generate
        if (LATENCY < 1 || Y_END < Y_START || Y_START < 0 || Y_END > (2 ** WIDTH) - 1) begin : g_bad_param
            $error("invert_ctrl: illegal LATENCY / Y_START / Y_END combination");
        end
    endgenerate

    localparam int               CW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0]    LOAD    = CW'(LATENCY - 1);
    localparam logic [WIDTH-1:0] Y_FIRST = WIDTH'(Y_START);
    localparam logic [WIDTH-1:0] Y_LAST  = WIDTH'(Y_END);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] res_y_q, res_y_d;
    logic [WIDTH-1:0] res_x_q, res_x_d;
    logic             res_valid_q, res_valid_d;
    logic             done_q, done_d;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_at_one;
    logic             skip_zero;

`ifdef INVERT_CTRL_SKIP_ZERO_EN
    assign skip_zero = (cur_q == '0);
`else
    assign skip_zero = 1'b0;
`endif

    invert_lat_cnt #(
        .CW (CW)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LOAD),
        .dec      (cnt_dec),
        .at_one   (cnt_at_one)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        res_y_d     = res_y_q;
        res_x_d     = res_x_q;
        res_valid_d = 1'b0;
        done_d      = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        y           = '0;
        start       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_LAUNCH;
                    cur_d   = Y_FIRST;
                end
            end
            ST_LAUNCH: begin
                y = cur_q;
                if (skip_zero) begin
                    state_d = ST_CAPTURE;
                end else begin
                    start = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d  = ST_WAIT;
                        cnt_load = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                y = cur_q;
                if (cnt_at_one) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_CAPTURE: begin
                y           = cur_q;
                res_valid_d = 1'b1;
                res_y_d     = cur_q;
                res_x_d     = skip_zero ? RES_ALL_ONES[WIDTH-1:0] : x;
                if (cur_q == Y_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cur_d   = cur_q + WIDTH'(1);
                    state_d = ST_LAUNCH;
                end
            end
            ST_DONE: begin
                // done is registered so it lands after the final res_valid, never with it.
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= Y_FIRST;
            res_y_q     <= '0;
            res_x_q     <= '0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            res_y_q     <= res_y_d;
            res_x_q     <= res_x_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
        end
    end

    assign res_y     = res_y_q;
    assign res_x     = res_x_q;
    assign res_valid = res_valid_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
